timer_dev: RTL and testbench
============================

TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 Parameters: none; register map and widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 DevAddr  input  [3:2]  register select, word-indexed.
REQ-005 WE  input  1  write enable for the selected register; full-word writes only.
REQ-006 WD  input  32  write data.
REQ-007 RD  output  32  read data, combinational from DevAddr and current register state.
REQ-008 Irq  output  1  interrupt request, registered pending flag ANDed with mask.

Function
REQ-009 Register map SHALL be:
- DevAddr 0: CTRL.
- DevAddr 1: PRESET (R/W, 32 bit).
- DevAddr 2: COUNT (read-only).
- DevAddr 3: reserved; reads 0, writes ignored.
REQ-010 CTRL fields SHALL be:
- [0] Enable.
- [2:1] Mode: 00 one-shot, 01 auto-reload; 10/11 behave as 00.
- [3] IM, interrupt mask, 1 = enabled.
- [31:4] read as 0, write ignored.
REQ-011 Writes SHALL take effect at the clock edge where WE=1; writes to DevAddr 2 or 3 SHALL have no effect.
REQ-012 RD SHALL return CTRL zero-extended, PRESET, COUNT or 0 for DevAddr 0..3 in the same cycle.
REQ-013 FSM states SHALL be IDLE, LOAD, CNT, INT.
REQ-014 IDLE: COUNT held; go to LOAD when Enable=1.
REQ-015 LOAD: COUNT <= PRESET; go to CNT.
REQ-016 CNT transitions SHALL be, in priority order:
- Enable=0: go to IDLE, COUNT held.
- COUNT <= 1: COUNT <= 0, go to INT.
- Otherwise: COUNT <= COUNT-1.
REQ-017 INT, mode 00: irq_pend <= 1, Enable <= 0, go to IDLE.
REQ-018 INT, mode 01: irq_pend <= 1, Enable unchanged, go to LOAD; irq_pend SHALL clear in LOAD, giving a one-cycle pulse.
REQ-019 In mode 00, irq_pend SHALL stay set until the next CTRL write, which clears it.
REQ-020 Irq SHALL equal irq_pend & IM; a change to IM SHALL affect Irq in the cycle after the write.
REQ-021 Timing, mode 00, PRESET=P >= 1, Enable written at edge 0:
- LOAD after edge 1.
- COUNT=P after edge 2.
- INT after edge P+2.
- Irq=1 after edge P+3.
PRESET=0 SHALL time identically to PRESET=1.
REQ-022 Mode 01 period SHALL be P+2 cycles between Irq pulses, for P >= 1.
REQ-023 A PRESET write during CNT SHALL NOT alter COUNT; it applies at the next LOAD.
REQ-024 If a software CTRL write and the INT-state Enable clear coincide, the software write SHALL win for all CTRL bits; irq_pend SHALL still set.
REQ-025 If a software CTRL write and the INT-state irq_pend set coincide, the set SHALL win.
REQ-026 COUNT SHALL never underflow below 0 or wrap.

Reset
REQ-027 While rst_n=0 at a clock edge, the following SHALL clear and WE SHALL be ignored:
- CTRL=0, PRESET=0, COUNT=0.
- state=IDLE, irq_pend=0, Irq=0.
REQ-028 Reset asserted mid-count SHALL abort counting with no Irq generated; operation resumes only after software re-enables.

Verification
REQ-029 Write PRESET=5, then CTRL=0x9 -> COUNT reads 5,4,3,2,1,0 on successive cycles; Irq=1 eight edges after the CTRL write; CTRL reads 0x8; Irq holds until a CTRL write of 0x8, then drops next cycle.
REQ-030 PRESET=3, CTRL=0xB (auto-reload, IM=1) -> Irq one-cycle pulses every 5 cycles; COUNT sequence 3,2,1,0 repeats; Enable stays 1.
REQ-031 PRESET=10, CTRL=0x1 (IM=0) -> count completes, irq_pend set, Irq stays 0; writing CTRL=0x8 clears irq_pend, so Irq stays 0.
REQ-032 During count, write PRESET=100 -> current count is unaffected; COUNT=100 only after the next LOAD.
REQ-033 During count, write CTRL=0x8 -> IDLE, COUNT frozen at its current value; rewrite CTRL=0x9 -> reload from PRESET.
REQ-034 Pull rst_n=0 for one edge at COUNT=4 -> all registers 0, Irq=0, FSM idle; reads at DevAddr 3 return 0 and writes there are ignored.

Source files
------------

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - programmable down-counting timer with one-shot/auto-reload modes and masked interrupt
module timer_dev (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:2]  DevAddr,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        Irq
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CNT,
        INT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;      // [0] enable, [2:1] mode, [3] irq mask
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_pend_q, irq_pend_d;

    logic        ctrl_wr;
    logic        preset_wr;
    logic        auto_reload;
    logic        pend_set;
    logic        pend_clr_load;
    logic        en_clr;

    assign ctrl_wr     = WE && (DevAddr == 2'd0);
    assign preset_wr   = WE && (DevAddr == 2'd1);
    // Only mode 01 reloads; 10 and 11 fall back to one-shot.
    assign auto_reload = (ctrl_q[2:1] == 2'b01);

    // Next state and COUNT update; also flags the side effects on CTRL and irq_pend.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        pend_set      = 1'b0;
        pend_clr_load = 1'b0;
        en_clr        = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_q[0]) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d       = preset_q;
                state_d       = CNT;
                // In auto-reload this ends the one-cycle pulse raised by INT.
                pend_clr_load = auto_reload;
            end
            CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = IDLE;
                end else if (count_q <= 32'd1) begin
                    // Saturate at zero so PRESET=0 behaves like PRESET=1.
                    count_d = 32'd0;
                    state_d = INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            INT: begin
                pend_set = 1'b1;
                if (auto_reload) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                    en_clr  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register file next values: a software CTRL write beats the hardware enable
    // clear, while the hardware pending set beats the software pending clear.
    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        irq_pend_d = irq_pend_q;
        if (ctrl_wr) begin
            ctrl_d = WD[3:0];
        end else if (en_clr) begin
            ctrl_d = {ctrl_q[3:1], 1'b0};
        end
        if (preset_wr) begin
            preset_d = WD;
        end
        if (pend_set) begin
            irq_pend_d = 1'b1;
        end else if (ctrl_wr || pend_clr_load) begin
            irq_pend_d = 1'b0;
        end
    end

    // State and register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    // Combinational read mux; the reserved slot reads as zero.
    always_comb begin
        RD = 32'd0;
        case (DevAddr)
            2'd0:    RD = {28'd0, ctrl_q};
            2'd1:    RD = preset_q;
            2'd2:    RD = count_q;
            default: RD = 32'd0;
        endcase
    end

    assign Irq = irq_pend_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - self-checking bench for timer_dev against a behavioural model
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:2]  DevAddr = 2'd0;
    logic        WE = 1'b0;
    logic [31:0] WD = 32'd0;
    logic [31:0] RD;
    logic        Irq;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    timer_dev dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .DevAddr (DevAddr),
        .WE      (WE),
        .WD      (WD),
        .RD      (RD),
        .Irq     (Irq)
    );

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] preset;
        logic [31:0] count;
        bit          pend;
        int          phase;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t s, logic rn, logic we,
                                           logic [1:0] a, logic [31:0] d);
        mstate_t n = s;
        bit auto_m = (s.ctrl[2:1] == 2'b01);
        if (!rn) begin
            n.ctrl = 4'd0; n.preset = 32'd0; n.count = 32'd0;
            n.pend = 1'b0; n.phase = PH_IDLE;
            return n;
        end
        case (s.phase)
            PH_IDLE: if (s.ctrl[0]) n.phase = PH_LOAD;
            PH_LOAD: begin
                n.count = s.preset;
                n.phase = PH_CNT;
                if (auto_m) n.pend = 1'b0;
            end
            PH_CNT: begin
                if (!s.ctrl[0]) n.phase = PH_IDLE;
                else if (s.count <= 1) begin n.count = 32'd0; n.phase = PH_INT; end
                else n.count = s.count - 1;
            end
            default: begin
                n.phase = auto_m ? PH_LOAD : PH_IDLE;
                if (!auto_m) n.ctrl[0] = 1'b0;
            end
        endcase
        if (we && a == 2'd1) n.preset = d;
        if (we && a == 2'd0) begin n.ctrl = d[3:0]; n.pend = 1'b0; end
        if (s.phase == PH_INT) n.pend = 1'b1;
        return n;
    endfunction

    function automatic logic [31:0] model_rd(mstate_t s, logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, s.ctrl};
            2'd1:    return s.preset;
            2'd2:    return s.count;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) m <= model_next(m, rst_n, WE, DevAddr, WD);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_model", RD, model_rd(m, DevAddr));
            chk("irq_model", 32'(Irq), 32'(m.pend & m.ctrl[3]));
        end
    end

    task automatic cyc(input bit we, input logic [1:0] a, input logic [31:0] d);
        WE = we; DevAddr = a; WD = d;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        WE = 1'b0; DevAddr = a;
        #1;
        chk(name, RD, exp);
    endtask

    initial begin
        int highs;
        int first;
        logic [31:0] d;
        logic [1:0] a;
        bit we;

        rst_n = 1'b0;
        cyc(1'b1, 2'd1, 32'hFFFF);
        cyc(1'b1, 2'd0, 32'hF);
        rst_n = 1'b1;
        chk_en = 1'b1;
        rd(2'd0, 32'd0, "rst_ctrl");
        rd(2'd1, 32'd0, "rst_preset");
        rd(2'd2, 32'd0, "rst_count");
        chk("rst_irq", 32'(Irq), 32'd0);

        // One-shot with mask: COUNT 5..0, Irq eight edges after enable
        cyc(1'b1, 2'd1, 32'd5);
        cyc(1'b1, 2'd0, 32'h9);
        cyc(1'b0, 2'd2, 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 2'd2, 32'd0);
            chk("r29_count", RD, 32'(5 - k));
            chk("r29_irq_low", 32'(Irq), 32'd0);
        end
        cyc(1'b0, 2'd2, 32'd0);
        chk("r29_irq_on", 32'(Irq), 32'd1);
        rd(2'd0, 32'h8, "r29_ctrl");
        repeat (4) cyc(1'b0, 2'd0, 32'd0);
        chk("r29_irq_hold", 32'(Irq), 32'd1);
        cyc(1'b1, 2'd0, 32'h8);
        chk("r29_irq_off", 32'(Irq), 32'd0);

        // Auto-reload: one-cycle pulses every 5 cycles
        cyc(1'b1, 2'd1, 32'd3);
        cyc(1'b1, 2'd0, 32'hB);
        highs = 0;
        first = 0;
        for (int e = 1; e <= 25; e++) begin
            cyc(1'b0, 2'd2, 32'd0);
            if (Irq) begin
                highs++;
                if (first == 0) first = e;
            end
        end
        chk("r30_pulses", 32'(highs), 32'd4);
        chk("r30_first", 32'(first), 32'd6);
        rd(2'd0, 32'hB, "r30_ctrl");
        cyc(1'b1, 2'd0, 32'h0);

        // Masked one-shot: pending sets, Irq stays low
        cyc(1'b1, 2'd1, 32'd10);
        cyc(1'b1, 2'd0, 32'h1);
        repeat (14) cyc(1'b0, 2'd2, 32'd0);
        chk("r31_irq_masked", 32'(Irq), 32'd0);
        cyc(1'b1, 2'd0, 32'h8);
        chk("r31_irq_after", 32'(Irq), 32'd0);

        // PRESET write during count, stop mid-count, re-enable
        cyc(1'b1, 2'd1, 32'd6);
        cyc(1'b1, 2'd0, 32'h1);
        repeat (3) cyc(1'b0, 2'd2, 32'd0);
        cyc(1'b1, 2'd1, 32'd100);
        cyc(1'b0, 2'd2, 32'd0);
        chk("r32_count_unaffected", RD, 32'd3);
        repeat (4) cyc(1'b0, 2'd2, 32'd0);
        rd(2'd1, 32'd100, "r32_preset");
        cyc(1'b1, 2'd0, 32'h1);
        cyc(1'b0, 2'd2, 32'd0);
        cyc(1'b0, 2'd2, 32'd0);
        chk("r32_reload", RD, 32'd100);
        cyc(1'b1, 2'd0, 32'h8);
        cyc(1'b0, 2'd2, 32'd0);
        cyc(1'b0, 2'd2, 32'd0);
        chk("r33_frozen", RD, 32'd99);
        cyc(1'b1, 2'd0, 32'h9);
        cyc(1'b0, 2'd2, 32'd0);
        cyc(1'b0, 2'd2, 32'd0);
        chk("r33_reload", RD, 32'd100);
        cyc(1'b1, 2'd0, 32'h0);

        // Reset mid-count at COUNT=4
        cyc(1'b1, 2'd1, 32'd10);
        cyc(1'b1, 2'd0, 32'h9);
        repeat (8) cyc(1'b0, 2'd2, 32'd0);
        rd(2'd2, 32'd4, "r34_pre");
        rst_n = 1'b0;
        cyc(1'b1, 2'd1, 32'd77);
        rst_n = 1'b1;
        rd(2'd0, 32'd0, "r34_ctrl");
        rd(2'd1, 32'd0, "r34_preset");
        rd(2'd2, 32'd0, "r34_count");
        chk("r34_irq", 32'(Irq), 32'd0);
        cyc(1'b1, 2'd3, 32'hFFFF_FFFF);
        rd(2'd3, 32'd0, "r34_reserved");
        repeat (20) cyc(1'b0, 2'd2, 32'd0);
        chk("r34_idle_count", RD, 32'd0);
        chk("r34_idle_irq", 32'(Irq), 32'd0);

        // Randomized traffic checked against the model every cycle
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            we = ($urandom_range(0, 5) == 0);
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd1) d = 32'($urandom_range(0, 12));
            else if (a == 2'd0 && $urandom_range(0, 2) != 0) d[0] = 1'b1;
            cyc(we, a, d);
        end
        rst_n = 1'b1;

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
